// File: rtl/msi_directory_controller_pkg.sv
// Shared MSI definitions: sizes, request/directory codes,
// FSM states and the per-transaction plan bundle.
package msi_pkg;

  localparam int N_PROC = 2;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int N_BLK  = 1 << ADDR_W;
  localparam int PW     = (N_PROC > 1) ? $clog2(N_PROC) : 1;

  typedef enum logic [1:0] {
    SIG_NONE = 2'b00,
    SIG_RD   = 2'b01,
    SIG_WR   = 2'b10,
    SIG_INV  = 2'b11
  } sig_e;

  typedef enum logic [1:0] {
    DIR_U = 2'b00,
    DIR_S = 2'b01,
    DIR_E = 2'b10
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_INVAL,
    ST_FETCH,
    ST_WB,
    ST_MEMRD,
    ST_REPLY
  } fsm_e;

  typedef enum logic [1:0] {
    RS_MEM,
    RS_OWN,
    RS_ZERO
  } rsrc_e;

  typedef struct packed {
    logic [N_PROC-1:0] inv;
    logic [N_PROC-1:0] own;
    logic              fetch;
    logic              fetchInv;
    logic              mem;
    rsrc_e             src;
    dir_e              st;
    logic [N_PROC-1:0] sh;
  } plan_t;

endpackage

// File: rtl/msi_directory_controller_if.sv
// Cache/memory side bundle of the directory controller.
// slave = directory view, master = caches + memory view.
interface msi_dir_if;
  import msi_pkg::*;

  logic [2*N_PROC-1:0]      ReqSignal;
  logic [ADDR_W*N_PROC-1:0] ReqAddr;
  logic                     OwnerAck;
  logic [DATA_W-1:0]        OwnerData;
  logic [DATA_W-1:0]        MemRdData;
  logic [N_PROC-1:0]        Grant;
  logic [N_PROC-1:0]        Fetch;
  logic                     FetchInv;
  logic [ADDR_W-1:0]        FetchAddr;
  logic [N_PROC-1:0]        Inval;
  logic                     MemRead;
  logic                     MemWrite;
  logic [ADDR_W-1:0]        MemAddr;
  logic [DATA_W-1:0]        MemWrData;
  logic [N_PROC-1:0]        ReplyValid;
  logic [DATA_W-1:0]        ReplyData;
  logic                     Busy;

  modport slave (
    input  ReqSignal, ReqAddr, OwnerAck,
    input  OwnerData, MemRdData,
    output Grant, Fetch, FetchInv, FetchAddr,
    output Inval, MemRead, MemWrite, MemAddr,
    output MemWrData, ReplyValid, ReplyData,
    output Busy
  );

  modport master (
    output ReqSignal, ReqAddr, OwnerAck,
    output OwnerData, MemRdData,
    input  Grant, Fetch, FetchInv, FetchAddr,
    input  Inval, MemRead, MemWrite, MemAddr,
    input  MemWrData, ReplyValid, ReplyData,
    input  Busy
  );

endinterface

// File: rtl/msi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of first requester at/after
// ptr; ptr moves past the winner when adv is set.
module msi_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt,
  output logic [((N>1)?$clog2(N):1)-1:0] win
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        win       = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= (win == IW'(N-1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/msi_directory_controller.sv
// MSI home directory: RR-arbitrates L1 requests, sequences
// inval/fetch/writeback/memory read, replies, updates directory.
module msi_directory_controller
  import msi_pkg::*;
(
  input  logic      Clock,
  input  logic      Resetn,
  msi_dir_if.slave  bus
);

  fsm_e st, stNx;

  logic [N_PROC-1:0] reqVec;
  logic [N_PROC-1:0] gnt;
  logic [PW-1:0]     win;

  logic [1:0]        dirSt [N_BLK];
  logic [N_PROC-1:0] dirSh [N_BLK];

  logic [N_PROC-1:0] reqOh;
  sig_e              reqSig;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] ownData;
  plan_t             plan, pl;

  dir_e              curSt;
  logic [N_PROC-1:0] curSh;
  logic [N_PROC-1:0] others;
  logic              eOther;
  logic              isRd;
  logic              upg;

  always_comb begin
    for (int i = 0; i < N_PROC; i++) begin
      reqVec[i] = |bus.ReqSignal[2*i +: 2];
    end
  end

  msi_rr_arbiter #(.N(N_PROC)) uArb (
    .clk   (Clock),
    .rst_n (Resetn),
    .req   (reqVec),
    .adv   (st == ST_IDLE),
    .gnt   (gnt),
    .win   (win)
  );

  // In E the sharer vector holds the single owner.
  always_comb begin
    curSt  = dir_e'(dirSt[addr]);
    curSh  = dirSh[addr];
    others = curSh & ~reqOh;
    eOther = (curSt == DIR_E) && (|others);
    isRd   = (reqSig == SIG_RD);
    upg    = (reqSig == SIG_INV) && (curSt == DIR_S)
             && (|(curSh & reqOh));
    plan.inv      = '0;
    plan.own      = others;
    plan.fetch    = 1'b0;
    plan.fetchInv = 1'b0;
    plan.mem      = 1'b1;
    plan.src      = RS_MEM;
    plan.st       = curSt;
    plan.sh       = curSh;
    unique case (1'b1)
      isRd && eOther: begin
        plan.fetch = 1'b1;
        plan.mem   = 1'b0;
        plan.src   = RS_OWN;
        plan.st    = DIR_S;
        plan.sh    = curSh | reqOh;
      end
      isRd && (curSt == DIR_E) && !eOther: begin
        plan.st = curSt;
      end
      isRd && (curSt != DIR_E): begin
        plan.st = DIR_S;
        plan.sh = curSh | reqOh;
      end
      upg: begin
        plan.inv = others;
        plan.mem = 1'b0;
        plan.src = RS_ZERO;
        plan.st  = DIR_E;
        plan.sh  = reqOh;
      end
      default: begin
        // WriteMiss, or an Invalidate that lost its race
        plan.st = DIR_E;
        plan.sh = reqOh;
        if (curSt == DIR_S) plan.inv = others;
        if (eOther) begin
          plan.fetch    = 1'b1;
          plan.fetchInv = 1'b1;
          plan.mem      = 1'b0;
          plan.src      = RS_OWN;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      st <= ST_IDLE;
    end else begin
      st <= stNx;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      reqOh   <= '0;
      reqSig  <= SIG_NONE;
      addr    <= '0;
      ownData <= '0;
      pl      <= '0;
      for (int b = 0; b < N_BLK; b++) begin
        dirSt[b] <= DIR_U;
        dirSh[b] <= '0;
      end
    end else begin
      if (st == ST_IDLE && (|reqVec)) begin
        reqOh  <= gnt;
        reqSig <= sig_e'(bus.ReqSignal[2*win +: 2]);
        addr   <= bus.ReqAddr[ADDR_W*win +: ADDR_W];
      end
      if (st == ST_LOOKUP) pl <= plan;
      if (st == ST_FETCH && bus.OwnerAck) begin
        ownData <= bus.OwnerData;
      end
      if (st == ST_REPLY) begin
        dirSt[addr] <= pl.st;
        dirSh[addr] <= pl.sh;
      end
    end
  end

  always_comb begin
    stNx = st;
    unique case (st)
      ST_IDLE:   if (|reqVec) stNx = ST_LOOKUP;
      ST_LOOKUP: stNx = (|plan.inv) ? ST_INVAL :
                        plan.fetch  ? ST_FETCH :
                        plan.mem    ? ST_MEMRD : ST_REPLY;
      ST_INVAL:  stNx = pl.fetch ? ST_FETCH :
                        pl.mem   ? ST_MEMRD : ST_REPLY;
      ST_FETCH:  if (bus.OwnerAck) stNx = ST_WB;
      ST_WB:     stNx = pl.mem ? ST_MEMRD : ST_REPLY;
      ST_MEMRD:  stNx = ST_REPLY;
      ST_REPLY:  stNx = ST_IDLE;
      default:   stNx = ST_IDLE;
    endcase

    // Grant is combinational from the requests; keep it
    // quiet while reset is held.
    bus.Grant      = (st == ST_IDLE && Resetn) ? gnt : '0;
    bus.Fetch      = (st == ST_FETCH) ? pl.own : '0;
    bus.FetchInv   = (st == ST_FETCH) && pl.fetchInv;
    bus.FetchAddr  = addr;
    bus.Inval      = (st == ST_INVAL) ? pl.inv : '0;
    bus.MemRead    = (st == ST_MEMRD);
    bus.MemWrite   = (st == ST_WB);
    bus.MemAddr    = addr;
    bus.MemWrData  = (st == ST_WB) ? ownData : '0;
    bus.ReplyValid = (st == ST_REPLY) ? reqOh : '0;
    bus.ReplyData  = '0;
    if (st == ST_REPLY) begin
      if (pl.src == RS_MEM) bus.ReplyData = bus.MemRdData;
      if (pl.src == RS_OWN) bus.ReplyData = ownData;
    end
    bus.Busy       = (st != ST_IDLE);
  end

endmodule

// File: tb/tb_msi_directory_controller.sv
// Scoreboard bench for msi_directory_controller: random L1
// requests, memory/owner responders, abstract directory model.
module tb_msi_directory_controller;
  import msi_pkg::*;

  logic clk = 1'b0;
  logic Resetn;

  msi_dir_if bus();

  msi_directory_controller dut (
    .Clock  (clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int proc;
    int addr;
    int inval;
    int owner;
    int fInv;
    int mem;
    int kind;
    int data;
    int grantCyc;
  } exp_t;

  exp_t expQ[$];

  int refSt [N_BLK];
  int refSh [N_BLK];
  int refMem[N_BLK];
  logic [3:0] memArr[N_BLK];
  int refPtr;

  bit ackEn;
  int lastOwn;
  int ackCyc;

  task automatic check(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] outs();
    return {bus.Grant, bus.Fetch, bus.FetchInv,
            bus.FetchAddr, bus.Inval, bus.MemRead,
            bus.MemWrite, bus.MemAddr, bus.MemWrData,
            bus.ReplyValid, bus.ReplyData, bus.Busy};
  endfunction

  // Memory and owner-cache responders
  initial begin
    int waitCnt, target;
    waitCnt = 0;
    target = 0;
    bus.OwnerAck = 1'b0;
    bus.OwnerData = '0;
    bus.MemRdData = '0;
    forever begin
      @(negedge clk);
      if (bus.MemWrite) memArr[bus.MemAddr] = bus.MemWrData;
      if (bus.MemRead) bus.MemRdData = memArr[bus.MemAddr];
      if (bus.OwnerAck) begin
        bus.OwnerAck = 1'b0;
        waitCnt = 0;
        target = $urandom_range(0, 3);
      end else if (bus.Fetch != 0) begin
        if (ackEn) begin
          if (waitCnt >= target) begin
            bus.OwnerData = 4'($urandom_range(0, 15));
            bus.OwnerAck = 1'b1;
            lastOwn = int'(bus.OwnerData);
            ackCyc = cyc;
          end else begin
            waitCnt++;
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // stray ack outside a fetch must be ignored
        bus.OwnerData = 4'($urandom_range(0, 15));
        bus.OwnerAck = 1'b1;
      end
    end
  end

  // Reference model + monitor
  initial begin
    bit act;
    int win, j, a, sig, st, sh, rq, oth;
    int invSeen, fSeen, fInvSeen, rdCnt, wrCnt, wbD;
    int addrBad, curAddr, expData, expLat, anyReq;
    exp_t e, c;
    act = 0;
    refPtr = 0;
    curAddr = 0;
    forever begin
      @(negedge clk);
      if (!Resetn) begin
        expQ.delete();
        act = 0;
        refPtr = 0;
        for (int i = 0; i < N_BLK; i++) begin
          refSt[i] = 0;
          refSh[i] = 0;
        end
      end else if (bus.Grant != 0) begin
        win = -1;
        for (int k = 0; k < N_PROC; k++) begin
          j = (refPtr + k) % N_PROC;
          if (win < 0 && bus.ReqSignal[2*j +: 2] != 0) win = j;
        end
        check("grant", int'(bus.Grant), win < 0 ? 0 : (1 << win));
        check("busy_at_grant", int'(bus.Busy), 0);
        if (win >= 0) begin
          sig = int'(bus.ReqSignal[2*win +: 2]);
          a = int'(bus.ReqAddr[4*win +: 4]);
          st = refSt[a];
          sh = refSh[a];
          rq = 1 << win;
          oth = sh & ~rq;
          e.proc = win;
          e.addr = a;
          e.inval = 0;
          e.owner = 0;
          e.fInv = 0;
          e.mem = 1;
          e.kind = 0;
          e.data = refMem[a];
          e.grantCyc = cyc;
          if (sig == 1) begin
            if (st == 2 && oth != 0) begin
              e.owner = oth;
              e.mem = 0;
              e.kind = 1;
              refSt[a] = 1;
              refSh[a] = sh | rq;
            end else if (st != 2) begin
              refSt[a] = 1;
              refSh[a] = sh | rq;
            end
          end else if (sig == 3 && st == 1 && (sh & rq) != 0) begin
            e.inval = oth;
            e.mem = 0;
            e.kind = 2;
            refSt[a] = 2;
            refSh[a] = rq;
          end else begin
            if (st == 1) e.inval = oth;
            if (st == 2 && oth != 0) begin
              e.owner = oth;
              e.fInv = 1;
              e.mem = 0;
              e.kind = 1;
            end
            refSt[a] = 2;
            refSh[a] = rq;
          end
          expQ.push_back(e);
          refPtr = (win + 1) % N_PROC;
          curAddr = a;
          act = 1;
          invSeen = 0;
          fSeen = 0;
          fInvSeen = 0;
          rdCnt = 0;
          wrCnt = 0;
          wbD = 0;
          addrBad = 0;
        end
      end else if (act) begin
        invSeen |= int'(bus.Inval);
        fSeen |= int'(bus.Fetch);
        if (bus.Fetch != 0 && bus.FetchInv) fInvSeen = 1;
        if (bus.MemRead) rdCnt++;
        if (bus.MemWrite) begin
          wrCnt++;
          wbD = int'(bus.MemWrData);
        end
        if ((bus.MemRead || bus.MemWrite)
            && int'(bus.MemAddr) != curAddr) addrBad = 1;
        if ((bus.Fetch != 0 || bus.Inval != 0)
            && int'(bus.FetchAddr) != curAddr) addrBad = 1;
        if (bus.ReplyValid != 0) begin
          act = 0;
          if (expQ.size() == 0) begin
            check("reply_unexpected", int'(bus.ReplyValid), 0);
          end else begin
            c = expQ.pop_front();
            expData = (c.kind == 0) ? c.data :
                      (c.kind == 1) ? lastOwn : 0;
            check("reply_proc", int'(bus.ReplyValid), 1 << c.proc);
            check("reply_data", int'(bus.ReplyData), expData);
            check("inval_set", invSeen, c.inval);
            check("fetch_owner", fSeen, c.owner);
            check("fetch_inv", fInvSeen, c.fInv);
            check("mem_read", rdCnt, c.mem);
            check("mem_write", wrCnt, (c.kind == 1) ? 1 : 0);
            check("addr", addrBad, 0);
            check("busy_in_reply", int'(bus.Busy), 1);
            if (c.kind == 1) begin
              check("wb_data", wbD, lastOwn);
              refMem[c.addr] = lastOwn;
              expLat = ackCyc + 2 - c.grantCyc;
            end else begin
              expLat = (c.mem ? 3 : 2) + ((c.inval != 0) ? 1 : 0);
            end
            check("latency", cyc - c.grantCyc, expLat);
          end
        end
      end else begin
        anyReq = (bus.ReqSignal != 0) ? 1 : 0;
        check("idle_quiet", int'(outs()), 0);
        check("idle_no_starve", anyReq, 0);
      end
    end
  end

  task automatic reqOnce(input int p, input int sig, input int a);
    int cnt;
    @(posedge clk);
    #1;
    bus.ReqSignal[2*p +: 2] = 2'(sig);
    bus.ReqAddr[4*p +: 4] = 4'(a);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.ReplyValid[p] && cnt < 300);
    check("req_done", int'(bus.ReplyValid[p]), 1);
    #1;
    bus.ReqSignal[2*p +: 2] = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    Resetn = 1'b0;
    ackEn = 1'b1;
    bus.ReqSignal = '0;
    bus.ReqAddr = '0;
    for (int i = 0; i < N_BLK; i++) begin
      refMem[i] = $urandom_range(0, 15);
      memArr[i] = 4'(refMem[i]);
    end
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", int'(outs()), 0);
    @(posedge clk);
    #2 Resetn = 1'b1;

    reqOnce(0, 1, 1);
    reqOnce(1, 1, 1);
    reqOnce(0, 3, 1);
    reqOnce(1, 1, 1);
    reqOnce(1, 3, 2);
    repeat (2) begin
      fork
        reqOnce(0, 1, 3);
        reqOnce(1, 1, 3);
      join
    end

    fork
      begin
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          reqOnce(0, $urandom_range(1, 3), $urandom_range(0, 3));
        end
      end
      begin
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          reqOnce(1, $urandom_range(1, 3), $urandom_range(0, 3));
        end
      end
    join

    // Abort a fetch with reset
    ackEn = 1'b0;
    reqOnce(0, 2, 9);
    @(posedge clk);
    #1;
    bus.ReqSignal[3:2] = 2'b01;
    bus.ReqAddr[7:4] = 4'd9;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.Fetch == 0 && cnt < 20);
    check("fetch_before_reset", int'(bus.Fetch), 1);
    check("fetchinv_read", int'(bus.FetchInv), 0);
    #1 Resetn = 1'b0;
    #1;
    check("reset_mid_fetch", int'(outs()), 0);
    bus.ReqSignal = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 Resetn = 1'b1;
    ackEn = 1'b1;
    reqOnce(1, 1, 9);
    fork
      reqOnce(0, 1, 10);
      reqOnce(1, 2, 10);
    join
    reqOnce(0, 1, 10);

    cnt = 0;
    while (expQ.size() != 0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("drain", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
